// File: rtl/snake_kbd_pkg.sv
// Shared types, scan codes and helpers for the snake keyboard/direction path.
// Optional WASD decoding (SNAKE_DIR_WASD_EN) is selected in snake_direction_ctrl.
package snake_kbd_pkg;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_RIGHT = 2'd1,
      DIR_DOWN  = 2'd2,
      DIR_LEFT  = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      CMD_NONE  = 2'd0,
      CMD_DIR   = 2'd1,
      CMD_PAUSE = 2'd2,
      CMD_START = 2'd3
   } cmd_t;

   localparam logic [7:0] KEY_UP    = 8'h75;
   localparam logic [7:0] KEY_DOWN  = 8'h72;
   localparam logic [7:0] KEY_LEFT  = 8'h6B;
   localparam logic [7:0] KEY_RIGHT = 8'h74;
   localparam logic [7:0] KEY_SPACE = 8'h29;
   localparam logic [7:0] KEY_ENTER = 8'h5A;
   localparam logic [7:0] KEY_W     = 8'h1D;
   localparam logic [7:0] KEY_S     = 8'h1B;
   localparam logic [7:0] KEY_A     = 8'h1C;
   localparam logic [7:0] KEY_D     = 8'h23;

   // Opposite directions differ only in the upper encoding bit.
   function automatic dir_t opposite(input dir_t d);
      return dir_t'(d ^ 2'b10);
   endfunction

endpackage

// File: rtl/dir_fifo.sv
// Small synchronous FIFO of directions; push is accepted when full if a pop
// happens in the same cycle. Flush has priority over push/pop.
module dir_fifo
   import snake_kbd_pkg::*;
#(
   parameter int  DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          CLOCK_50,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [1:0]    din,
   output logic [1:0]    head,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty
);

   logic [1:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign head    = mem[rd_ptr];

   always_ff @(posedge CLOCK_50) begin
      if (push_ok && !flush)
         mem[wr_ptr] <= din;
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/snake_direction_ctrl.sv
// Keyboard-to-direction sequencer for the snake game: decode, run/pause FSM,
// enqueue filter and tick-driven release. Define SNAKE_DIR_WASD_EN to add WASD keys.
//
// state     | meaning
// ST_IDLE   | waiting for enter; keys and ticks ignored
// ST_RUN    | direction keys filtered into queue, ticks release entries
// ST_PAUSED | queue held, ticks ignored, direction keys dropped
module snake_direction_ctrl
   import snake_kbd_pkg::*;
#(
   parameter int   QUEUE_DEPTH = 4,
   parameter dir_t INIT_DIR    = DIR_RIGHT,
   localparam int  CW          = $clog2(QUEUE_DEPTH) + 1
) (
   input  logic          CLOCK_50,
   input  logic          reset,
   input  logic          key_valid,
   input  logic          key_make,
   input  logic [7:0]    key_code,
   input  logic          tick,
   input  logic          game_over,
   output logic [1:0]    dir,
   output logic          dir_step,
   output logic          running,
   output logic          paused,
   output logic [CW-1:0] q_count,
   output logic          overflow
);

   state_t     state;
   state_t     state_nxt;
   cmd_t       cmd;
   dir_t       key_dir;
   dir_t       dir_r;
   dir_t       last_dir;
   logic       flush;
   logic       start;
   logic       run_now;
   logic       dir_ok;
   logic       pop_en;
   logic       push_en;
   logic       fifo_full;
   logic       fifo_empty;
   logic [1:0] fifo_head;

   always_comb begin
      cmd     = CMD_NONE;
      key_dir = DIR_UP;
      if (key_valid && key_make) begin
         case (key_code)
            KEY_UP:    begin cmd = CMD_DIR; key_dir = DIR_UP;    end
            KEY_DOWN:  begin cmd = CMD_DIR; key_dir = DIR_DOWN;  end
            KEY_LEFT:  begin cmd = CMD_DIR; key_dir = DIR_LEFT;  end
            KEY_RIGHT: begin cmd = CMD_DIR; key_dir = DIR_RIGHT; end
`ifdef SNAKE_DIR_WASD_EN
            KEY_W:     begin cmd = CMD_DIR; key_dir = DIR_UP;    end
            KEY_S:     begin cmd = CMD_DIR; key_dir = DIR_DOWN;  end
            KEY_A:     begin cmd = CMD_DIR; key_dir = DIR_LEFT;  end
            KEY_D:     begin cmd = CMD_DIR; key_dir = DIR_RIGHT; end
`else
`endif
            KEY_SPACE: cmd = CMD_PAUSE;
            KEY_ENTER: cmd = CMD_START;
            default:   cmd = CMD_NONE;
         endcase
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // game_over overrides any key decoded in the same cycle.
   always_comb begin
      state_nxt = state;
      flush     = 1'b0;
      start     = 1'b0;
      if (game_over) begin
         state_nxt = ST_IDLE;
         flush     = 1'b1;
      end else begin
         case (state)
            ST_IDLE:
               if (cmd == CMD_START) begin
                  state_nxt = ST_RUN;
                  flush     = 1'b1;
                  start     = 1'b1;
               end
            ST_RUN:
               if (cmd == CMD_PAUSE)
                  state_nxt = ST_PAUSED;
            ST_PAUSED:
               if (cmd == CMD_PAUSE)
                  state_nxt = ST_RUN;
            default:
               state_nxt = ST_IDLE;
         endcase
      end
   end

   assign run_now = !game_over && (state == ST_RUN);
   assign dir_ok  = run_now && (cmd == CMD_DIR) &&
                    (key_dir != last_dir) && (key_dir != opposite(last_dir));
   assign pop_en  = run_now && tick && !fifo_empty;
   assign push_en = dir_ok && (!fifo_full || pop_en);

   dir_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .push     (push_en),
      .pop      (pop_en),
      .flush    (flush),
      .din      (key_dir),
      .head     (fifo_head),
      .count    (q_count),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         dir_r    <= INIT_DIR;
         last_dir <= INIT_DIR;
         dir_step <= 1'b0;
         running  <= 1'b0;
         paused   <= 1'b0;
         overflow <= 1'b0;
      end else begin
         dir_step <= run_now && tick;
         overflow <= dir_ok && fifo_full && !pop_en;
         running  <= (state_nxt == ST_RUN);
         paused   <= (state_nxt == ST_PAUSED);
         if (start) begin
            dir_r    <= INIT_DIR;
            last_dir <= INIT_DIR;
         end else begin
            if (pop_en)
               dir_r <= dir_t'(fifo_head);
            if (push_en)
               last_dir <= key_dir;
         end
      end
   end

   assign dir = dir_r;

endmodule
